// File: rtl/axis_pkg.sv
// Shared stream package: arbiter FSM states and default stream widths used by
// axis_rr_arbiter and axis_out_reg.
package axis_pkg;

   localparam int DATA_SIZE_DEF = 32;
   localparam int STRB_W        = DATA_SIZE_DEF / 8;
   localparam int CNT_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// One-deep registered AXI-Stream output stage; loads whenever the register is
// empty or being drained, and holds every output while the sink stalls.
module axis_out_reg
   import axis_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [DATA_SIZE-1:0]   in_data,
   input  logic [DATA_SIZE/8-1:0] in_strb,
   input  logic                   in_last,
   input  logic                   out_ready,
   output logic                   out_free,
   output logic [DATA_SIZE-1:0]   out_data,
   output logic [DATA_SIZE/8-1:0] out_strb,
   output logic                   out_valid,
   output logic                   out_last
);

   logic [DATA_SIZE-1:0]   tdata_q, tdata_d;
   logic [DATA_SIZE/8-1:0] tstrb_q, tstrb_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q, tlast_d;

   // in_valid must only be raised while out_free is high; the caller gates it.
   assign out_free = ~tvalid_q | out_ready;

   always_comb begin
      tdata_d  = tdata_q;
      tstrb_d  = tstrb_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      if (out_free) begin
         tvalid_d = in_valid;
         if (in_valid) begin
            tdata_d = in_data;
            tstrb_d = in_strb;
            tlast_d = in_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tdata_q  <= '0;
         tstrb_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         tdata_q  <= tdata_d;
         tstrb_q  <= tstrb_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

   assign out_data  = tdata_q;
   assign out_strb  = tstrb_q;
   assign out_valid = tvalid_q;
   assign out_last  = tlast_q;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing m00 between s00 and s01.
// Optional per-source packet counters are enabled with AXIS_ARB_STATS_EN.
module axis_rr_arbiter
   import axis_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                   axis_aclk,
   input  logic                   axis_areset,
   input  logic                   arb_enable,
   input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
   input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
   input  logic                   s00_axis_tvalid,
   input  logic                   s00_axis_tlast,
   output logic                   s00_axis_tready,
   input  logic [DATA_SIZE-1:0]   s01_axis_tdata,
   input  logic [DATA_SIZE/8-1:0] s01_axis_tstrb,
   input  logic                   s01_axis_tvalid,
   input  logic                   s01_axis_tlast,
   output logic                   s01_axis_tready,
   output logic [DATA_SIZE-1:0]   m00_axis_tdata,
   output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
   output logic                   m00_axis_tvalid,
   output logic                   m00_axis_tlast,
   input  logic                   m00_axis_tready,
   output logic [1:0]             arb_grant
`ifdef AXIS_ARB_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]   pkt_cnt0,
   output logic [CNT_WIDTH-1:0]   pkt_cnt1
`endif
);

   arb_state_e             state_q, state_d;
   logic                   last_grant_q, last_grant_d;
   logic                   out_free;
   logic                   beat0, beat1, eop0, eop1;
   logic [DATA_SIZE-1:0]   sel_data;
   logic [DATA_SIZE/8-1:0] sel_strb;
   logic                   sel_last;

   // Handshake: a beat moves on an edge where tvalid && tready; tready depends
   // combinationally on m00_axis_tready so the output register streams at full rate.
   assign s00_axis_tready = (state_q == GRANT0) && out_free;
   assign s01_axis_tready = (state_q == GRANT1) && out_free;
   assign beat0 = s00_axis_tvalid && s00_axis_tready;
   assign beat1 = s01_axis_tvalid && s01_axis_tready;
   assign eop0  = beat0 && s00_axis_tlast;
   assign eop1  = beat1 && s01_axis_tlast;
   assign arb_grant = {state_q == GRANT1, state_q == GRANT0};

   always_comb begin
      sel_data = s00_axis_tdata;
      sel_strb = s00_axis_tstrb;
      sel_last = s00_axis_tlast;
      if (state_q == GRANT1) begin
         sel_data = s01_axis_tdata;
         sel_strb = s01_axis_tstrb;
         sel_last = s01_axis_tlast;
      end
   end

   // last_grant_q names the source served most recently; the other wins a tie.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (arb_enable) begin
               if (s00_axis_tvalid && s01_axis_tvalid) begin
                  state_d = last_grant_q ? GRANT0 : GRANT1;
               end else if (s00_axis_tvalid) begin
                  state_d = GRANT0;
               end else if (s01_axis_tvalid) begin
                  state_d = GRANT1;
               end
            end
         end
         GRANT0: begin
            if (eop0) begin
               state_d      = IDLE;
               last_grant_d = 1'b0;
            end
         end
         GRANT1: begin
            if (eop1) begin
               state_d      = IDLE;
               last_grant_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   axis_out_reg #(
      .DATA_SIZE (DATA_SIZE)
   ) u_out_reg (
      .clk       (axis_aclk),
      .rst       (axis_areset),
      .in_valid  (beat0 | beat1),
      .in_data   (sel_data),
      .in_strb   (sel_strb),
      .in_last   (sel_last),
      .out_ready (m00_axis_tready),
      .out_free  (out_free),
      .out_data  (m00_axis_tdata),
      .out_strb  (m00_axis_tstrb),
      .out_valid (m00_axis_tvalid),
      .out_last  (m00_axis_tlast)
   );

`ifdef AXIS_ARB_STATS_EN
   logic [CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d;
   logic [CNT_WIDTH-1:0] pkt_cnt1_q, pkt_cnt1_d;

   always_comb begin
      pkt_cnt0_d = pkt_cnt0_q;
      pkt_cnt1_d = pkt_cnt1_q;
      if (eop0) pkt_cnt0_d = pkt_cnt0_q + CNT_WIDTH'(1);
      if (eop1) pkt_cnt1_d = pkt_cnt1_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         pkt_cnt0_q <= '0;
         pkt_cnt1_q <= '0;
      end else begin
         pkt_cnt0_q <= pkt_cnt0_d;
         pkt_cnt1_q <= pkt_cnt1_d;
      end
   end

   assign pkt_cnt0 = pkt_cnt0_q;
   assign pkt_cnt1 = pkt_cnt1_q;
`else
   // Counters are compiled out; this keeps CNT_WIDTH referenced.
   logic [CNT_WIDTH-1:0] unused_cnt_width;
   assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (define AXIS_ARB_STATS_EN
// to also exercise the packet counters).
module tb_axis_rr_arbiter;

   logic        clk = 1'b0;
   logic        axis_areset = 1'b1;
   logic        arb_enable = 1'b0;
   logic [31:0] s00_tdata = '0, s01_tdata = '0;
   logic [3:0]  s00_tstrb = '0, s01_tstrb = '0;
   logic        s00_tvalid = 1'b0, s01_tvalid = 1'b0;
   logic        s00_tlast = 1'b0, s01_tlast = 1'b0;
   logic        s00_tready, s01_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic        m_tvalid, m_tlast;
   logic        m_tready = 1'b0;
   logic [1:0]  arb_grant;
`ifdef AXIS_ARB_STATS_EN
   logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   logic [32:0] obs_q[$];
   int          obs_cyc[$];
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   axis_rr_arbiter dut (
      .axis_aclk       (clk),
      .axis_areset     (axis_areset),
      .arb_enable      (arb_enable),
      .s00_axis_tdata  (s00_tdata),
      .s00_axis_tstrb  (s00_tstrb),
      .s00_axis_tvalid (s00_tvalid),
      .s00_axis_tlast  (s00_tlast),
      .s00_axis_tready (s00_tready),
      .s01_axis_tdata  (s01_tdata),
      .s01_axis_tstrb  (s01_tstrb),
      .s01_axis_tvalid (s01_tvalid),
      .s01_axis_tlast  (s01_tlast),
      .s01_axis_tready (s01_tready),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tstrb  (m_tstrb),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tlast  (m_tlast),
      .m00_axis_tready (m_tready),
      .arb_grant       (arb_grant)
`ifdef AXIS_ARB_STATS_EN
      ,
      .pkt_cnt0        (pkt_cnt0),
      .pkt_cnt1        (pkt_cnt1)
`endif
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Every beat the sink accepts, tagged with the cycle it was presented.
   always @(negedge clk) begin
      if (!axis_areset && m_tvalid && m_tready) begin
         obs_q.push_back({m_tlast, m_tdata});
         obs_cyc.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int src, input logic v, input logic [31:0] d, input logic l);
      if (src == 0) begin
         s00_tvalid = v; s00_tdata = d; s00_tstrb = 4'(d); s00_tlast = l;
      end else begin
         s01_tvalid = v; s01_tdata = d; s01_tstrb = 4'(d); s01_tlast = l;
      end
   endtask

   task automatic send_pkt(input int src, input int n, input logic [31:0] base, input bit end_last);
      for (int i = 0; i < n; i++) begin
         automatic bit hs = 1'b0;
         automatic int budget = 0;
         drive(src, 1'b1, base + 32'(i), end_last && (i == n - 1));
         while (!hs) begin
            @(negedge clk);
            hs = (src == 0) ? (s00_tvalid && s00_tready) : (s01_tvalid && s01_tready);
            step();
            budget++;
            if (!hs && budget > 200) begin
               total_cnt++;
               $display("FAIL handshake_timeout src=%0d beat=%h: got no tready, want tready within 200 cycles", src, base + 32'(i));
               drive(src, 1'b0, '0, 1'b0);
               return;
            end
         end
      end
      drive(src, 1'b0, '0, 1'b0);
   endtask

   task automatic reset_dut();
      axis_areset = 1'b1;
      step();
      axis_areset = 1'b0;
   endtask

   task automatic test_reset();
      step(); step();
      @(negedge clk);
      total_cnt++; if (m_tdata !== 32'h0) $display("FAIL rst_tdata: got %h want 0", m_tdata); else pass_cnt++;
      total_cnt++; if (m_tstrb !== 4'h0) $display("FAIL rst_tstrb: got %h want 0", m_tstrb); else pass_cnt++;
      total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_tvalid); else pass_cnt++;
      total_cnt++; if (m_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", m_tlast); else pass_cnt++;
      total_cnt++; if ({s01_tready, s00_tready} !== 2'b00) $display("FAIL rst_tready: got %b want 00", {s01_tready, s00_tready}); else pass_cnt++;
      total_cnt++; if (arb_grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", arb_grant); else pass_cnt++;
      step();
      axis_areset = 1'b0;
      arb_enable = 1'b1;
      m_tready = 1'b1;
   endtask

   task automatic test_single_src();
      drive(0, 1'b1, 32'd1, 1'b0);
      @(negedge clk);
      total_cnt++; if (arb_grant !== 2'b00 || s00_tready !== 1'b0) $display("FAIL single_bubble: got grant=%b rdy=%b want 00/0", arb_grant, s00_tready); else pass_cnt++;
      step();
      @(negedge clk);
      total_cnt++; if (arb_grant !== 2'b01 || s00_tready !== 1'b1) $display("FAIL single_grant: got grant=%b rdy=%b want 01/1", arb_grant, s00_tready); else pass_cnt++;
      total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL single_pre_valid: got %b want 0", m_tvalid); else pass_cnt++;
      step();
      drive(0, 1'b1, 32'd3, 1'b0);
      @(negedge clk);
      total_cnt++; if ({m_tvalid, m_tlast, m_tstrb, m_tdata} !== {1'b1, 1'b0, 4'h1, 32'd1}) $display("FAIL single_beat1: got v=%b l=%b s=%h d=%h want 1/0/1/1", m_tvalid, m_tlast, m_tstrb, m_tdata); else pass_cnt++;
      step();
      drive(0, 1'b1, 32'd9, 1'b1);
      @(negedge clk);
      total_cnt++; if ({m_tvalid, m_tlast, m_tstrb, m_tdata} !== {1'b1, 1'b0, 4'h3, 32'd3}) $display("FAIL single_beat2: got v=%b l=%b s=%h d=%h want 1/0/3/3", m_tvalid, m_tlast, m_tstrb, m_tdata); else pass_cnt++;
      total_cnt++; if (arb_grant !== 2'b01) $display("FAIL single_grant_mid: got %b want 01", arb_grant); else pass_cnt++;
      step();
      drive(0, 1'b0, '0, 1'b0);
      @(negedge clk);
      total_cnt++; if ({m_tvalid, m_tlast, m_tstrb, m_tdata} !== {1'b1, 1'b1, 4'h9, 32'd9}) $display("FAIL single_beat3: got v=%b l=%b s=%h d=%h want 1/1/9/9", m_tvalid, m_tlast, m_tstrb, m_tdata); else pass_cnt++;
      total_cnt++; if (arb_grant !== 2'b00) $display("FAIL single_release: got %b want 00", arb_grant); else pass_cnt++;
      step();
      @(negedge clk);
      total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL single_drain: got %b want 0", m_tvalid); else pass_cnt++;
      step();
   endtask

   task automatic test_back_to_back();
      reset_dut();
      obs_q.delete(); obs_cyc.delete();
      fork
         begin send_pkt(0, 2, 32'h10, 1'b1); send_pkt(0, 2, 32'h12, 1'b1); end
         begin send_pkt(1, 2, 32'h20, 1'b1); send_pkt(1, 2, 32'h22, 1'b1); end
      join
      repeat (3) step();
      exp_q = '{{1'b0, 32'h10}, {1'b1, 32'h11}, {1'b0, 32'h20}, {1'b1, 32'h21},
                {1'b0, 32'h12}, {1'b1, 32'h13}, {1'b0, 32'h22}, {1'b1, 32'h23}};
      total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) begin
         automatic logic [32:0] got = (i < obs_q.size()) ? obs_q[i] : 'x;
         total_cnt++; if (got !== exp_q[i]) $display("FAIL b2b_order[%0d]: got %h want %h", i, got, exp_q[i]); else pass_cnt++;
      end
      for (int i = 1; i < obs_cyc.size() && i < 8; i++) begin
         automatic int want = (i % 2 == 0) ? 2 : 1;
         total_cnt++; if (obs_cyc[i] - obs_cyc[i-1] != want) $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, obs_cyc[i] - obs_cyc[i-1], want); else pass_cnt++;
      end
   endtask

   task automatic test_stall();
      logic [3:0] pat = 4'b1001;
      obs_q.delete(); obs_cyc.delete();
      fork
         send_pkt(1, 4, 32'h30, 1'b1);
         begin
            automatic bit prev_stall = 1'b0;
            automatic logic [32:0] prev_out = '0;
            for (int c = 0; c < 20; c++) begin
               m_tready = pat[3 - (c % 4)];
               @(negedge clk);
               if (prev_stall) begin
                  total_cnt++; if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, prev_out}) $display("FAIL stall_hold c=%0d: got %h want %h", c, {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_out}); else pass_cnt++;
               end
               if (m_tvalid && !m_tready) begin
                  total_cnt++; if (s01_tready !== 1'b0) $display("FAIL stall_tready c=%0d: got %b want 0", c, s01_tready); else pass_cnt++;
               end
               prev_stall = m_tvalid && !m_tready;
               prev_out = {m_tlast, m_tdata};
               step();
            end
            m_tready = 1'b1;
         end
      join
      repeat (2) step();
      exp_q = '{{1'b0, 32'h30}, {1'b0, 32'h31}, {1'b0, 32'h32}, {1'b1, 32'h33}};
      total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) begin
         automatic logic [32:0] got = (i < obs_q.size()) ? obs_q[i] : 'x;
         total_cnt++; if (got !== exp_q[i]) $display("FAIL stall_data[%0d]: got %h want %h", i, got, exp_q[i]); else pass_cnt++;
      end
   endtask

   task automatic test_hold_grant();
      obs_q.delete(); obs_cyc.delete();
      fork
         begin
            send_pkt(0, 2, 32'h40, 1'b0);
            repeat (5) begin
               @(negedge clk);
               total_cnt++; if (arb_grant !== 2'b01 || s01_tready !== 1'b0) $display("FAIL hold_gap: got grant=%b s01_rdy=%b want 01/0", arb_grant, s01_tready); else pass_cnt++;
               step();
            end
            send_pkt(0, 2, 32'h42, 1'b1);
         end
         begin
            automatic int w = 0;
            while (w < 50) begin
               @(negedge clk);
               if (arb_grant == 2'b01) break;
               step();
               w++;
            end
            if (w >= 50) begin
               total_cnt++;
               $display("FAIL hold_wait_grant: got grant=%b want 01 within 50 cycles", arb_grant);
            end
            step();
            send_pkt(1, 1, 32'h50, 1'b1);
         end
      join
      repeat (3) step();
      exp_q = '{{1'b0, 32'h40}, {1'b0, 32'h41}, {1'b0, 32'h42}, {1'b1, 32'h43}, {1'b1, 32'h50}};
      total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL hold_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) begin
         automatic logic [32:0] got = (i < obs_q.size()) ? obs_q[i] : 'x;
         total_cnt++; if (got !== exp_q[i]) $display("FAIL hold_data[%0d]: got %h want %h", i, got, exp_q[i]); else pass_cnt++;
      end
   endtask

   task automatic test_enable();
      obs_q.delete(); obs_cyc.delete();
      arb_enable = 1'b0;
      drive(0, 1'b1, 32'h60, 1'b0);
      drive(1, 1'b1, 32'h70, 1'b1);
      repeat (4) begin
         @(negedge clk);
         total_cnt++; if (arb_grant !== 2'b00 || m_tvalid !== 1'b0) $display("FAIL en_off: got grant=%b tvalid=%b want 00/0", arb_grant, m_tvalid); else pass_cnt++;
         step();
      end
      arb_enable = 1'b1;
      fork
         send_pkt(0, 3, 32'h60, 1'b1);
         begin
            automatic int w = 0;
            while (w < 50) begin
               @(negedge clk);
               if (arb_grant == 2'b01) break;
               step();
               w++;
            end
            if (w >= 50) begin
               total_cnt++;
               $display("FAIL en_wait_grant: got grant=%b want 01 within 50 cycles", arb_grant);
            end
            step();
            arb_enable = 1'b0;
         end
      join
      repeat (4) begin
         @(negedge clk);
         total_cnt++; if (arb_grant !== 2'b00 || s01_tready !== 1'b0) $display("FAIL en_after: got grant=%b s01_rdy=%b want 00/0", arb_grant, s01_tready); else pass_cnt++;
         step();
      end
      exp_q = '{{1'b0, 32'h60}, {1'b0, 32'h61}, {1'b1, 32'h62}};
      total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL en_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) begin
         automatic logic [32:0] got = (i < obs_q.size()) ? obs_q[i] : 'x;
         total_cnt++; if (got !== exp_q[i]) $display("FAIL en_data[%0d]: got %h want %h", i, got, exp_q[i]); else pass_cnt++;
      end
      drive(1, 1'b0, '0, 1'b0);
      arb_enable = 1'b1;
      step();
   endtask

   task automatic test_reset_mid();
      automatic int beats = 0;
      automatic int w = 0;
      obs_q.delete(); obs_cyc.delete();
      drive(0, 1'b1, 32'h80, 1'b0);
      while (beats < 2 && w < 40) begin
         automatic bit hs;
         @(negedge clk);
         hs = s00_tvalid && s00_tready;
         step();
         w++;
         if (hs) begin
            beats++;
            drive(0, 1'b1, 32'h80 + 32'(beats), 1'b0);
         end
      end
      if (beats < 2) begin
         total_cnt++;
         $display("FAIL rmid_timeout: got %0d beats want 2", beats);
      end
      axis_areset = 1'b1;
      step();
      @(negedge clk);
      total_cnt++; if ({m_tvalid, m_tlast, m_tstrb, m_tdata} !== 38'h0) $display("FAIL rmid_out: got v=%b l=%b s=%h d=%h want all 0", m_tvalid, m_tlast, m_tstrb, m_tdata); else pass_cnt++;
      total_cnt++; if ({arb_grant, s01_tready, s00_tready} !== 4'b0000) $display("FAIL rmid_ctl: got grant=%b rdy=%b%b want 00/00", arb_grant, s01_tready, s00_tready); else pass_cnt++;
      total_cnt++; if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 32'h80}) $display("FAIL rmid_partial: got %0d beats want one beat 080 without tlast", obs_q.size()); else pass_cnt++;
      step();
      axis_areset = 1'b0;
      obs_q.delete(); obs_cyc.delete();
      fork
         send_pkt(0, 1, 32'hA0, 1'b1);
         send_pkt(1, 1, 32'h90, 1'b1);
         begin
            automatic int v = 0;
            while (v < 50) begin
               @(negedge clk);
               if (arb_grant != 2'b00) break;
               step();
               v++;
            end
            total_cnt++; if (arb_grant !== 2'b01) $display("FAIL rmid_first_grant: got %b want 01", arb_grant); else pass_cnt++;
         end
      join
      repeat (3) step();
      exp_q = '{{1'b1, 32'hA0}, {1'b1, 32'h90}};
      total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL rmid_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) begin
         automatic logic [32:0] got = (i < obs_q.size()) ? obs_q[i] : 'x;
         total_cnt++; if (got !== exp_q[i]) $display("FAIL rmid_data[%0d]: got %h want %h", i, got, exp_q[i]); else pass_cnt++;
      end
   endtask

`ifdef AXIS_ARB_STATS_EN
   task automatic test_stats();
      reset_dut();
      @(negedge clk);
      total_cnt++; if (pkt_cnt0 !== 16'h0 || pkt_cnt1 !== 16'h0) $display("FAIL stats_reset: got %h/%h want 0000/0000", pkt_cnt0, pkt_cnt1); else pass_cnt++;
      step();
      send_pkt(0, 1, 32'hB0, 1'b1);
      send_pkt(0, 2, 32'hB1, 1'b1);
      send_pkt(0, 1, 32'hB3, 1'b1);
      dut.pkt_cnt1_q = 16'hFFFF;
      send_pkt(1, 2, 32'hC0, 1'b1);
      repeat (3) step();
      @(negedge clk);
      total_cnt++; if (pkt_cnt0 !== 16'd3) $display("FAIL stats_cnt0: got %0d want 3", pkt_cnt0); else pass_cnt++;
      total_cnt++; if (pkt_cnt1 !== 16'd0) $display("FAIL stats_cnt1_wrap: got %0d want 0", pkt_cnt1); else pass_cnt++;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_single_src();
      test_back_to_back();
      test_stall();
      test_hold_grant();
      test_enable();
      test_reset_mid();
`ifdef AXIS_ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
